onchip_memory_dp: RTL and testbench

// - Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2), pipelined reads
//   (readdatavalid), byte-enable writes, a deterministic write-collision policy and optional

---
 rtl/onchip_memory_dp.sv | 148 ++++++++++++++
 tb/tb_onchip_memory_dp.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, byte-enable writes,
// pipelined reads (readdatavalid) and an optional zero-clear sweep after reset.
module onchip_memory_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 13,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    s1_chipselect,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic                    s2_chipselect,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clear_addr;
    logic                    ready;
    logic                    clear_we;

    logic [ADDR_WIDTH-1:0]   addr  [2];
    logic [BE_WIDTH-1:0]     be    [2];
    logic [DATA_WIDTH-1:0]   wdata [2];
    logic [1:0]              wr_en;
    logic [1:0]              rd_en;

    logic [DATA_WIDTH-1:0]   mem   [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_q [2];
    logic [1:0]              v1;
    logic [DATA_WIDTH-1:0]   out_data [2];
    logic [1:0]              out_valid;

    assign ready          = (state == ST_READY);
    assign s1_waitrequest = ~ready | ~clken;
    assign s2_waitrequest = ~ready | ~clken;

    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;

    // A write wins over a simultaneous read on the same port: no read is issued.
    assign wr_en[0] = reset_n & ready & clken & s1_chipselect & s1_write;
    assign wr_en[1] = reset_n & ready & clken & s2_chipselect & s2_write;
    assign rd_en[0] = reset_n & ready & clken & s1_chipselect & s1_read & ~s1_write;
    assign rd_en[1] = reset_n & ready & clken & s2_chipselect & s2_read & ~s2_write;

    assign clear_we = reset_n & clken & (state == ST_CLEAR) & (CLEAR_ON_RESET != 0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_CLEAR;
            clear_addr <= '0;
        end else if (state == ST_CLEAR) begin
            if (CLEAR_ON_RESET == 0) begin
                state <= ST_READY;
            end else if (clken) begin
                clear_addr <= clear_addr + 1'b1;
                if (clear_addr == '1) state <= ST_READY;
            end
        end
    end

    // NOTE: the array and its read registers carry no reset so they map onto block RAM;
    // contents survive reset_n and only the clear sweep zeroes them.
    always_ff @(posedge clk) begin
        if (clear_we) mem[clear_addr] <= '0;
        // s2 lanes are written first so any lane s1 also enables ends up with s1 data.
        for (int p = 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (be[p][i]) mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) ram_q[p] <= mem[addr[p]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) v1 <= '0;
        else if (clken) v1 <= rd_en;
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] q2 [2];
        logic [1:0]            v2;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                v2    <= '0;
                q2[0] <= '0;
                q2[1] <= '0;
            end else if (clken) begin
                v2 <= v1;
                for (int p = 0; p < 2; p++) begin
                    if (v1[p]) q2[p] <= ram_q[p];
                end
            end
        end

        assign out_data[0] = q2[0];
        assign out_data[1] = q2[1];
        assign out_valid   = v2;
    end else begin : g_lat1
        // Masks the unreset RAM register so readdata is zero until the first read lands.
        logic [1:0] primed;

        always_ff @(posedge clk) begin
            if (!reset_n)   primed <= '0;
            else if (clken) primed <= primed | rd_en;
        end

        assign out_data[0] = primed[0] ? ram_q[0] : '0;
        assign out_data[1] = primed[1] ? ram_q[1] : '0;
        assign out_valid   = v1;
    end

    // A valid flag frozen by clken=0 is shown only once the pipeline moves again.
    assign s1_readdata      = out_data[0];
    assign s2_readdata      = out_data[1];
    assign s1_readdatavalid = out_valid[0] & clken;
    assign s2_readdatavalid = out_valid[1] & clken;

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Bench for onchip_memory_dp: two instances (latency 2 with clear sweep, latency 1 without)
// driven in lockstep, checked every cycle against a behavioural model plus directed literals.
module tb_onchip_memory_dp;
    localparam int M_LAT   [2] = '{2, 1};
    localparam int M_DEPTH [2] = '{16, 32};
    localparam int M_CLR   [2] = '{1, 0};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clken;
    logic        cs     [2];
    logic        rdreq  [2];
    logic        wrreq  [2];
    logic [3:0]  be     [2];
    logic [31:0] wdata  [2];
    logic [4:0]  addr   [2];

    logic [31:0] q_data  [2][2];
    logic        q_valid [2][2];
    logic        q_wait  [2][2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_chipselect(cs[0]), .s1_address(addr[0][3:0]), .s1_read(rdreq[0]), .s1_write(wrreq[0]),
        .s1_byteenable(be[0]), .s1_writedata(wdata[0]), .s1_readdata(q_data[0][0]),
        .s1_readdatavalid(q_valid[0][0]), .s1_waitrequest(q_wait[0][0]),
        .s2_chipselect(cs[1]), .s2_address(addr[1][3:0]), .s2_read(rdreq[1]), .s2_write(wrreq[1]),
        .s2_byteenable(be[1]), .s2_writedata(wdata[1]), .s2_readdata(q_data[0][1]),
        .s2_readdatavalid(q_valid[0][1]), .s2_waitrequest(q_wait[0][1])
    );

    onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_chipselect(cs[0]), .s1_address(addr[0]), .s1_read(rdreq[0]), .s1_write(wrreq[0]),
        .s1_byteenable(be[0]), .s1_writedata(wdata[0]), .s1_readdata(q_data[1][0]),
        .s1_readdatavalid(q_valid[1][0]), .s1_waitrequest(q_wait[1][0]),
        .s2_chipselect(cs[1]), .s2_address(addr[1]), .s2_read(rdreq[1]), .s2_write(wrreq[1]),
        .s2_byteenable(be[1]), .s2_writedata(wdata[1]), .s2_readdata(q_data[1][1]),
        .s2_readdatavalid(q_valid[1][1]), .s2_waitrequest(q_wait[1][1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] data;
        bit          known;
        int          due;
    } rd_t;

    logic [31:0] mm [2][32];
    bit          mk [2][32];
    bit          m_ready [2];
    int          m_clr   [2];
    int          m_cnt = 0;
    rd_t         pend [2][2][$];
    logic [31:0] last_data  [2][2];
    bit          last_known [2][2];
    int          last_due   [2][2];
    bit          armed = 1'b0;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 32; w++) begin
                mm[d][w] = '0;
                mk[d][w] = 1'b0;
            end
    end

    // m_cnt counts clock edges on which the read pipeline advances; a read
    // accepted on the edge taking m_cnt to c+1 surfaces when m_cnt reaches c+latency.
    always @(posedge clk) begin
        if (!reset_n) armed = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_ready[d] = 1'b0;
                m_clr[d]   = 0;
                for (int p = 0; p < 2; p++) begin
                    pend[d][p].delete();
                    last_data[d][p]  = '0;
                    last_known[d][p] = 1'b1;
                    last_due[d][p]   = -1;
                end
            end else if (!m_ready[d]) begin
                if (M_CLR[d] == 0) m_ready[d] = 1'b1;
                else if (clken) begin
                    mm[d][m_clr[d]] = '0;
                    mk[d][m_clr[d]] = 1'b1;
                    m_clr[d]++;
                    if (m_clr[d] == M_DEPTH[d]) m_ready[d] = 1'b1;
                end
            end else if (clken) begin
                for (int p = 0; p < 2; p++) begin
                    int a;
                    a = int'(addr[p]) % M_DEPTH[d];
                    if (cs[p] && rdreq[p] && !wrreq[p])
                        pend[d][p].push_back('{data: mm[d][a], known: mk[d][a], due: m_cnt + M_LAT[d]});
                end
                for (int p = 0; p < 2; p++) begin
                    int a;
                    int a1;
                    a  = int'(addr[p]) % M_DEPTH[d];
                    a1 = int'(addr[0]) % M_DEPTH[d];
                    if (cs[p] && wrreq[p]) begin
                        for (int i = 0; i < 4; i++) begin
                            // a lane s1 also writes at the same word belongs to s1
                            if (be[p][i] && !(p == 1 && cs[0] && wrreq[0] && a1 == a && be[0][i]))
                                mm[d][a][8*i +: 8] = wdata[p][8*i +: 8];
                        end
                        if (be[p] == 4'hf) mk[d][a] = 1'b1;
                    end
                end
            end
        end
        if (reset_n && clken) begin
            m_cnt++;
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++)
                    if (pend[d][p].size() > 0 && pend[d][p][0].due == m_cnt) begin
                        last_data[d][p]  = pend[d][p][0].data;
                        last_known[d][p] = pend[d][p][0].known;
                        last_due[d][p]   = m_cnt;
                        void'(pend[d][p].pop_front());
                    end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    check($sformatf("d%0d_s%0d_waitrequest", d, p + 1), 32'(q_wait[d][p]),
                          32'(!m_ready[d] || !clken));
                    check($sformatf("d%0d_s%0d_readdatavalid", d, p + 1), 32'(q_valid[d][p]),
                          32'((last_due[d][p] == m_cnt) && clken));
                    if (last_known[d][p])
                        check($sformatf("d%0d_s%0d_readdata", d, p + 1), q_data[d][p], last_data[d][p]);
                end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] got [2][2][$];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                if (q_valid[d][p] === 1'b1) got[d][p].push_back(q_data[d][p]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            cs[p] = 1'b0; rdreq[p] = 1'b0; wrreq[p] = 1'b0;
            be[p] = '0;   wdata[p] = '0;   addr[p]  = '0;
        end
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        cs[p] = 1'b1; wrreq[p] = 1'b1; rdreq[p] = 1'b0;
        addr[p] = a;  wdata[p] = d;    be[p] = b;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        cs[p] = 1'b1; rdreq[p] = 1'b1; wrreq[p] = 1'b0; addr[p] = a; be[p] = '0;
    endtask

    task automatic flush();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) got[d][p].delete();
    endtask

    function automatic logic [31:0] got_at(input int d, input int p, input int i);
        return (got[d][p].size() > i) ? got[d][p][i] : 32'hBAD0BAD0;
    endfunction

    task automatic read_word(input int p, input logic [4:0] a, output logic [31:0] da, output logic [31:0] db);
        flush();
        rd(p, a);
        tick();
        idle();
        repeat (4) tick();
        check("read_word_count_a", got[0][p].size(), 1);
        check("read_word_count_b", got[1][p].size(), 1);
        da = got_at(0, p, 0);
        db = got_at(1, p, 0);
    endtask

    initial begin
        logic [31:0] da, db, acc;
        int n, lat_a, lat_b, total;

        idle();
        clken   = 1'b1;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        // clear sweep: waitrequest stays high for DEPTH=16 cycles on the clearing instance
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q_wait[0][0]) n++;
            else break;
        end
        check("clear_wait_cycles", n, 16);
        check("noclear_ready", 32'(q_wait[1][0]), 0);

        flush();
        for (int a = 0; a < 16; a++) begin
            rd(0, 5'(a));
            tick();
        end
        idle();
        repeat (4) tick();
        check("clear_read_count", got[0][0].size(), 16);
        acc = '0;
        for (int i = 0; i < 16; i++) acc = acc | got_at(0, 0, i);
        check("clear_words_zero", acc, 32'h0);

        // latency: 2 on dut_a, 1 on dut_b
        wr(0, 5'h10, 32'hDEADBEEF, 4'hf);
        tick();
        flush();
        rd(0, 5'h10);
        tick();
        idle();
        lat_a = 0;
        lat_b = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (q_valid[0][0] && lat_a == 0) lat_a = k;
            if (q_valid[1][0] && lat_b == 0) lat_b = k;
            tick();
        end
        check("latency_a", lat_a, 2);
        check("latency_b", lat_b, 1);
        check("latency_data_a", got_at(0, 0, 0), 32'hDEADBEEF);
        check("latency_data_b", got_at(1, 0, 0), 32'hDEADBEEF);

        // byte lanes and same-address collision
        wr(0, 5'h3, 32'h0, 4'hf);
        tick();
        wr(0, 5'h3, 32'h11111111, 4'b0011);
        wr(1, 5'h3, 32'h22222222, 4'b0110);
        tick();
        idle();
        read_word(0, 5'h3, da, db);
        check("collision_a", da, 32'h00221111);
        check("collision_b", db, 32'h00221111);

        // read-during-write returns old data
        wr(0, 5'h5, 32'hAAAA5555, 4'hf);
        tick();
        flush();
        wr(0, 5'h5, 32'h12345678, 4'hf);
        rd(1, 5'h5);
        tick();
        idle();
        repeat (4) tick();
        check("rdw_old_a", got_at(0, 1, 0), 32'hAAAA5555);
        check("rdw_old_b", got_at(1, 1, 0), 32'hAAAA5555);
        read_word(1, 5'h5, da, db);
        check("rdw_new_a", da, 32'h12345678);
        check("rdw_new_b", db, 32'h12345678);

        // back-to-back reads with a 3-cycle clken stall mid-stream
        for (int a = 0; a < 3; a++) begin
            wr(0, 5'(a), 32'hA0 + 32'(a), 4'hf);
            tick();
        end
        flush();
        rd(0, 5'h0);
        tick();
        rd(0, 5'h1);
        tick();
        rd(0, 5'h2);
        clken = 1'b0;
        repeat (3) tick();
        clken = 1'b1;
        tick();
        idle();
        repeat (4) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("stall_count_d%0d", d), got[d][0].size(), 3);
            for (int i = 0; i < 3; i++)
                check($sformatf("stall_order_d%0d_%0d", d, i), got_at(d, 0, i), 32'hA0 + 32'(i));
        end

        // reset with reads in flight: nothing surfaces afterwards
        rd(0, 5'h0);
        tick();
        rd(0, 5'h1);
        tick();
        idle();
        reset_n = 1'b0;
        tick();
        flush();
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        total = 0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) total += got[d][p].size();
        check("no_valid_after_reset", total, 0);
        read_word(0, 5'h1, da, db);
        check("after_reset_cleared_a", da, 32'h0);
        check("after_reset_kept_b", db, 32'hA1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
